// File: rtl/noc_inject_sched.sv
// noc_inject_sched: round-robin, credit-limited flit injection into one
// NoC ingress channel, with a watchdog that drops stalled transfers.
module noc_inject_sched #(
    parameter int NUM_SRC = 16,
    parameter int FLIT_W  = 9,
    parameter int MAX_OUT = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [NUM_SRC-1:0]           req,
    input  logic [NUM_SRC*FLIT_W-1:0]    req_flit,
    output logic [NUM_SRC-1:0]           gnt,
    output logic                         out_valid,
    output logic [FLIT_W-1:0]            out_flit,
    output logic [$clog2(NUM_SRC)-1:0]   out_src,
    input  logic                         out_ready,
    input  logic [NUM_SRC-1:0]           ack_in,
    input  logic [NUM_SRC-1:0]           err_in,
    output logic                         timeout,
    output logic [7:0]                   err_cnt,
    output logic                         cred_ovf,
    output logic                         busy
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CW    = $clog2(MAX_OUT + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   nxt_rr;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   idx;
    logic               found;
    logic [CW-1:0]      credit [NUM_SRC];
    logic [CW-1:0]      nxt_credit [NUM_SRC];
    logic [WD_W-1:0]    wd;
    logic [WD_W-1:0]    nxt_wd;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] nxt_gnt;
    logic [FLIT_W-1:0]  nxt_flit;
    logic [SRC_W-1:0]   nxt_src;
    logic               cap;
    logic               drop;
    logic               nxt_ovf;
    logic [7:0]         nxt_err;
    logic [SRC_W:0]     err_pop;
    logic [8:0]         err_sum;
    logic [CW+1:0]      csum;

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);

    // A source may compete only while it requests and holds a credit.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_SRC; i++)
            elig[i] = req[i] && (credit[i] != '0);
    end

    // First eligible source after rr_ptr, wrapping; rr_ptr itself is last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = rr_ptr + SRC_W'(k + 1);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Next state and capture/complete/drop decisions.
    always_comb begin
        nxt_state = state;
        nxt_rr    = rr_ptr;
        nxt_wd    = wd;
        nxt_gnt   = '0;
        nxt_flit  = out_flit;
        nxt_src   = out_src;
        cap       = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    cap       = 1'b1;
                    nxt_flit  = req_flit[win*FLIT_W +: FLIT_W];
                    nxt_src   = win;
                    nxt_gnt   = NUM_SRC'(1) << win;
                    nxt_wd    = '0;
                    nxt_state = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    nxt_rr    = out_src;
                    nxt_state = IDLE;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    drop      = 1'b1;
                    nxt_rr    = out_src;
                    nxt_state = IDLE;
                end else begin
                    nxt_wd = wd + 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Per-source credit update; overflow clamps and is flagged sticky.
    always_comb begin
        nxt_ovf = cred_ovf;
        csum    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            csum = (CW+2)'(credit[i])
                 + (CW+2)'(ack_in[i] | err_in[i])
                 + (CW+2)'(drop && (out_src == SRC_W'(i)))
                 - (CW+2)'(cap && (win == SRC_W'(i)));
            if (csum > (CW+2)'(MAX_OUT)) begin
                nxt_credit[i] = CW'(MAX_OUT);
                nxt_ovf       = 1'b1;
            end else begin
                nxt_credit[i] = csum[CW-1:0];
            end
        end
    end

    // Saturating accumulation of error pulses.
    always_comb begin
        err_pop = '0;
        for (int i = 0; i < NUM_SRC; i++)
            err_pop = err_pop + (SRC_W+1)'(err_in[i]);
        err_sum = {1'b0, err_cnt} + 9'(err_pop);
        nxt_err = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    // Datapath, credits and status registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_ptr   <= SRC_W'(NUM_SRC - 1);
            wd       <= '0;
            gnt      <= '0;
            out_flit <= '0;
            out_src  <= '0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
            cred_ovf <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++)
                credit[i] <= CW'(MAX_OUT);
        end else begin
            rr_ptr   <= nxt_rr;
            wd       <= nxt_wd;
            gnt      <= nxt_gnt;
            out_flit <= nxt_flit;
            out_src  <= nxt_src;
            timeout  <= drop;
            err_cnt  <= nxt_err;
            cred_ovf <= nxt_ovf;
            for (int i = 0; i < NUM_SRC; i++)
                credit[i] <= nxt_credit[i];
        end
    end

endmodule

// File: tb/tb_noc_inject_sched.sv
// tb_noc_inject_sched: directed scenarios plus random traffic, compared
// cycle by cycle against a transaction-level model of the scheduler.
module tb_noc_inject_sched;

    localparam int N  = 16;
    localparam int FW = 9;
    localparam int TO = 64;

    logic          CLK;
    logic          r_rst;
    logic [N-1:0]  r_req;
    logic [FW-1:0] r_flit [N];
    logic          r_ready;
    logic [N-1:0]  r_ack;
    logic [N-1:0]  r_err;
    logic [N*FW-1:0] flit_bus;

    logic [N-1:0]  gnt;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic [3:0]    out_src;
    logic          timeout;
    logic [7:0]    err_cnt;
    logic          cred_ovf;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit          m_busy;
    int          m_src;
    int          m_flit;
    int          m_wait;
    int          m_last;
    int          m_cred [N];
    logic [N-1:0] m_gnt;
    bit          m_to;
    int          m_err;
    bit          m_ovf;

    noc_inject_sched #(
        .NUM_SRC(N), .FLIT_W(FW), .MAX_OUT(3), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RESET(r_rst), .req(r_req), .req_flit(flit_bus),
        .gnt(gnt), .out_valid(out_valid), .out_flit(out_flit),
        .out_src(out_src), .out_ready(r_ready), .ack_in(r_ack),
        .err_in(r_err), .timeout(timeout), .err_cnt(err_cnt),
        .cred_ovf(cred_ovf), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pack per-source flits onto the DUT bus.
    always_comb begin
        flit_bus = '0;
        for (int i = 0; i < N; i++)
            flit_bus[i*FW +: FW] = r_flit[i];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Effect of the coming clock edge, from the transaction rules.
    task automatic model_step();
        int cap;
        int ret;
        int pc;
        int c;
        logic [N-1:0] g;
        bit to;
        if (r_rst) begin
            m_busy = 0; m_src = 0; m_flit = 0; m_wait = 0;
            m_last = N - 1; m_gnt = '0; m_to = 0; m_err = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) m_cred[i] = 3;
            return;
        end
        cap = -1; ret = -1; g = '0; to = 0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (cap < 0 && r_req[j] && m_cred[j] > 0) cap = j;
            end
            if (cap >= 0) begin
                m_busy = 1; m_src = cap; m_flit = int'(r_flit[cap]);
                m_wait = 1; g[cap] = 1'b1;
            end
        end else if (r_ready) begin
            m_busy = 0; m_last = m_src;
        end else if (m_wait == TO) begin
            m_busy = 0; to = 1; ret = m_src; m_last = m_src;
        end else begin
            m_wait++;
        end
        for (int i = 0; i < N; i++) begin
            c = m_cred[i] + int'(r_ack[i] | r_err[i]);
            if (i == ret) c++;
            if (i == cap) c--;
            if (c > 3) begin c = 3; m_ovf = 1; end
            m_cred[i] = c;
        end
        pc = $countones(r_err);
        m_err = (m_err + pc > 255) ? 255 : m_err + pc;
        m_gnt = g;
        m_to  = to;
    endtask

    task automatic compare();
        check("valid", 32'(out_valid), 32'(m_busy));
        check("busy", 32'(busy), 32'(m_busy));
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("timeout", 32'(timeout), 32'(m_to));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("cred_ovf", 32'(cred_ovf), 32'(m_ovf));
        if (m_busy) begin
            check("out_src", 32'(out_src), 32'(m_src));
            check("out_flit", 32'(out_flit), 32'(m_flit));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        compare();
    endtask

    task automatic do_reset();
        r_rst = 1'b1; r_req = '0; r_ack = '0; r_err = '0; r_ready = 1'b1;
        tick();
        r_rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int nv;
        int stall;
        r_rst = 1'b1; r_req = '0; r_ack = '0; r_err = '0; r_ready = 1'b0;
        for (int i = 0; i < N; i++) r_flit[i] = FW'($urandom);
        @(negedge CLK);

        // reset state
        do_reset();
        check("rst_flit", 32'(out_flit), 0);
        check("rst_src", 32'(out_src), 0);
        check("rst_valid", 32'(out_valid), 0);

        // single source, immediate accept
        r_req = 16'h0001; r_flit[0] = 9'h1A5; r_ready = 1'b1;
        tick();
        check("t1_gnt", 32'(gnt), 32'h0001);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_src", 32'(out_src), 0);
        check("t1_flit", 32'(out_flit), 32'h1A5);
        r_req = '0;
        tick();
        check("t1_done", 32'(out_valid), 0);

        // round-robin order with all sources requesting
        do_reset();
        r_req = '1;
        cnt = 0;
        for (int t = 0; t < 34; t++) begin
            tick();
            if (gnt != '0) begin
                check("rr_order", 32'(gnt), 32'(1) << (cnt % N));
                r_flit[cnt % N] = FW'($urandom);
                cnt++;
            end
        end
        check("rr_count", 32'(cnt), 17);

        // credit limit and return on one source
        do_reset();
        r_req = 16'h0008;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (gnt[3]) cnt++;
        end
        check("cred_lim", 32'(cnt), 3);
        r_ack = 16'h0008;
        tick();
        if (gnt[3]) cnt++;
        r_ack = '0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (gnt[3]) cnt++;
        end
        check("cred_ret", 32'(cnt), 4);

        // watchdog drop and successor choice
        do_reset();
        r_req = 16'h0084; r_ready = 1'b0;
        tick();
        check("to_first", 32'(gnt), 32'h0004);
        nv = out_valid ? 1 : 0;
        for (int k = 0; k < 100 && !timeout; k++) begin
            tick();
            if (out_valid) nv++;
        end
        check("to_len", 32'(nv), TO);
        check("to_pulse", 32'(timeout), 1);
        tick();
        check("to_next", 32'(gnt), 32'h0080);

        // same-cycle capture and ack, then overflow, then err saturation
        do_reset();
        r_req = 16'h0020; r_ack = 16'h0020; r_ready = 1'b1;
        tick();
        check("net0_gnt", 32'(gnt), 32'h0020);
        r_req = '0; r_ack = '0;
        check("net0_ovf", 32'(cred_ovf), 0);
        tick();
        r_ack = 16'h0020;
        tick();
        r_ack = '0;
        check("ovf_set", 32'(cred_ovf), 1);
        r_err = '1;
        for (int t = 0; t < 20; t++) tick();
        r_err = '0;
        check("err_sat", 32'(err_cnt), 255);

        // reset in the middle of a stalled transfer
        do_reset();
        r_req = 16'h0010; r_ready = 1'b0; r_err = 16'h0003;
        tick();
        r_err = '0;
        for (int t = 0; t < 5; t++) tick();
        r_rst = 1'b1;
        tick();
        check("mid_valid", 32'(out_valid), 0);
        check("mid_to", 32'(timeout), 0);
        check("mid_err", 32'(err_cnt), 0);
        r_rst = 1'b0; r_req = '1; r_ready = 1'b1;
        tick();
        check("mid_first", 32'(gnt), 32'h0001);

        // random traffic against the model
        do_reset();
        stall = 0;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i]) begin
                    if ($urandom_range(1, 0) == 0) r_req[i] = 1'b0;
                    r_flit[i] = FW'($urandom);
                end else if (!r_req[i] && $urandom_range(3, 0) == 0) begin
                    r_req[i] = 1'b1;
                    r_flit[i] = FW'($urandom);
                end
                r_ack[i] = ($urandom_range(7, 0) == 0);
                r_err[i] = ($urandom_range(63, 0) == 0);
            end
            if (stall > 0) begin
                r_ready = 1'b0;
                stall--;
            end else begin
                r_ready = ($urandom_range(3, 0) != 0);
                if ($urandom_range(199, 0) == 0) stall = 70;
            end
            r_rst = ($urandom_range(1499, 0) == 0);
            if (r_rst) r_req = '0;
            tick();
        end
        r_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
